// File: rtl/inst_queue_dec.sv
// Code-byte prefetch queue and instruction length decoder feeding the control stage.
// Optional feature: define IQ_STARVE_CNT_EN to add the oStarveCnt starvation counter port.
module inst_queue_dec #(
    parameter int QDEPTH   = 16,
    parameter int PEND_MAX = 15
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iNew,
    input  logic        iJumped,
    input  logic        iCodeValid,
    input  logic        iCodeOdd,
    input  logic [15:0] iCodeData,
    output logic        oCodeRdy,
    output logic [7:0]  oInfoOp,
    input  logic        iInfoModRM,
    input  logic [1:0]  iInfoImm,
    input  logic [8:0]  iInfoUCAdr,
    input  logic        iInfoPLine,
    output logic        oAck,
    output logic [7:0]  oOP0,
    output logic [7:0]  oOP1,
    output logic [15:0] oImm,
    output logic [15:0] oOffset,
    output logic [2:0]  oUsed,
    output logic [8:0]  oUCAdr,
    output logic        oPipeLine
`ifdef IQ_STARVE_CNT_EN
    ,
    output logic [15:0] oStarveCnt
`endif
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(PEND_MAX + 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    typedef struct packed {
        logic [7:0]  op0;
        logic [7:0]  op1;
        logic [15:0] imm;
        logic [15:0] offset;
        logic [2:0]  used;
        logic [8:0]  ucadr;
        logic        pline;
    } rec_t;

    state_e         state_q, state_d;
    logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  pend_q, pend_d;
    logic           ack_q, ack_d;
    rec_t           rec_q, rec_d;
    logic [7:0]     mem_q [QDEPTH];

    logic [7:0]     qb [8];
    logic           run, clear, emit, push, have_inst;
    logic [1:0]     mode;
    logic [2:0]     d_len, i_len, len, imm_idx;
    logic [CW-1:0]  push_n, pop_n;
    logic           wr0_en, wr1_en;
    logic [AW-1:0]  wr0_addr, wr1_addr;
    logic [7:0]     wr0_data, wr1_data;

    // Window onto the first bytes of the queue, relative to head.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            qb[i] = mem_q[AW'(head_q + AW'(i))];
        end
    end

    assign oInfoOp  = qb[0];
    assign run      = (state_q == ST_RUN);
    assign oCodeRdy = run && (count_q <= CW'(QDEPTH - 2));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        mode      = qb[1][7:6];
        d_len     = 3'd0;
        if (iInfoModRM) begin
            unique case (mode)
                2'b00:   d_len = (qb[1][2:0] == 3'b110) ? 3'd2 : 3'd0;
                2'b01:   d_len = 3'd1;
                2'b10:   d_len = 3'd2;
                default: d_len = 3'd0;
            endcase
        end
        i_len     = (iInfoImm == 2'd3) ? 3'd2 : {1'b0, iInfoImm};
        len       = 3'd1 + {2'b00, iInfoModRM} + d_len + i_len;
        imm_idx   = 3'd1 + {2'b00, iInfoModRM} + d_len;
        have_inst = (count_q != '0) && (!iInfoModRM || count_q >= CW'(2))
                    && (count_q >= CW'(len));

        clear = iJumped || !run;
        emit  = run && !iJumped && (pend_q != '0 || iNew) && have_inst;
        push  = iCodeValid && oCodeRdy && !iJumped;

        push_n = push ? (iCodeOdd ? CW'(1) : CW'(2)) : '0;
        pop_n  = emit ? CW'(len) : '0;

        wr0_en   = push;
        wr1_en   = push && !iCodeOdd;
        wr0_addr = tail_q;
        wr1_addr = AW'(tail_q + AW'(1));
        wr0_data = iCodeOdd ? iCodeData[15:8] : iCodeData[7:0];
        wr1_data = iCodeData[15:8];

        head_d  = AW'(head_q + AW'(pop_n));
        tail_d  = AW'(tail_q + AW'(push_n));
        count_d = count_q + push_n - pop_n;

        pend_d = pend_q;
        if (iNew && !emit && pend_q != PW'(PEND_MAX)) begin
            pend_d = pend_q + PW'(1);
        end else if (!iNew && emit) begin
            pend_d = pend_q - PW'(1);
        end

        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pend_d  = '0;
        end

        state_d = state_q;
        if (run && iJumped) begin
            state_d = ST_FLUSH;
        end else if (!run && !iJumped) begin
            state_d = ST_RUN;
        end

        ack_d = emit;
        rec_d = rec_q;
        if (emit) begin
            rec_d.op0   = qb[0];
            rec_d.op1   = iInfoModRM ? qb[1] : 8'h00;
            rec_d.used  = len;
            rec_d.ucadr = iInfoUCAdr;
            rec_d.pline = iInfoPLine;
            unique case (d_len)
                3'd1:    rec_d.offset = {{8{qb[2][7]}}, qb[2]};
                3'd2:    rec_d.offset = {qb[3], qb[2]};
                default: rec_d.offset = 16'h0000;
            endcase
            unique case (i_len)
                3'd1:    rec_d.imm = {8'h00, qb[imm_idx]};
                3'd2:    rec_d.imm = {qb[imm_idx + 3'd1], qb[imm_idx]};
                default: rec_d.imm = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            ack_q   <= 1'b0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            rec_q   <= rec_d;
        end
    end

    // NOTE: the byte store is deliberately not reset; count/head/tail alone define what is valid.
    always_ff @(posedge iClk) begin
        if (wr0_en) mem_q[wr0_addr] <= wr0_data;
        if (wr1_en) mem_q[wr1_addr] <= wr1_data;
    end

    assign oAck      = ack_q;
    assign oOP0      = rec_q.op0;
    assign oOP1      = rec_q.op1;
    assign oImm      = rec_q.imm;
    assign oOffset   = rec_q.offset;
    assign oUsed     = rec_q.used;
    assign oUCAdr    = rec_q.ucadr;
    assign oPipeLine = rec_q.pline;

`ifdef IQ_STARVE_CNT_EN
    logic [15:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (run && pend_q != '0 && !have_inst && starve_q != 16'hFFFF) begin
            starve_d = starve_q + 16'd1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) starve_q <= '0;
        else      starve_q <= starve_d;
    end

    assign oStarveCnt = starve_q;
`endif

endmodule
